// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the draw sequencer: FSM states, default geometry,
// pipeline latency, counter widths and xySel codes.
package draw_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PRIME,
    S_DRAW,
    S_DONE
  } state_t;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned SPRITE_W_DEF = 40;
  localparam int unsigned SPRITE_H_DEF = 40;
  localparam int unsigned PIPE_LAT_DEF = 2;

  localparam int unsigned COL_BITS = 8;
  localparam int unsigned ROW_BITS = 7;
  localparam int unsigned PIX_BITS = 15;

  localparam logic [1:0] XY_SCREEN = 2'b00;
  localparam logic [1:0] XY_SPRITE = 2'b01;

endpackage

// File: rtl/draw_sequencer_if.sv
// Draw request handshake between a requester and the draw sequencer.
interface draw_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_kind;
  logic [4:0] req_mem;
  logic [3:0] req_xsel;
  logic [1:0] req_ysel;
  logic       req_black;

  modport master (
    output req_valid, req_kind, req_mem, req_xsel, req_ysel, req_black,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_kind, req_mem, req_xsel, req_ysel, req_black,
    output req_ready
  );
endinterface

// File: rtl/draw_sequencer_raster_counter.sv
// Column/row/pixel raster counters for one draw; they hold at end of frame
// rather than wrapping, and restart only on clear.
module raster_counter
  import draw_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                advance,
  input  logic [COL_BITS-1:0] w,
  input  logic [ROW_BITS-1:0] h,
  output logic [PIX_BITS-1:0] pix,
  output logic                end_of_row,
  output logic                end_of_frame
);

  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;

  assign end_of_row   = (col == w - COL_BITS'(1));
  assign end_of_frame = end_of_row && (row == h - ROW_BITS'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
      pix <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
      pix <= '0;
    end else if (advance && !end_of_frame) begin
      pix <= pix + PIX_BITS'(1);
      if (end_of_row) begin
        col <= '0;
        row <= row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Draw sequencer: accepts a screen/sprite draw request and sequences the
// coordinate datapath, ROM address counters and VGA plot strobe in raster order.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned SPRITE_W = SPRITE_W_DEF,
  parameter int unsigned SPRITE_H = SPRITE_H_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  draw_sequencer_if.slave        req,
  output logic xInitLoad, yInitLoad, xLoad, yLoad, xCountUp, yCountUp,
  output logic xInitReset, yInitReset, xReset, yReset,
  output logic [1:0] xySel,
  output logic [3:0] xInitSel,
  output logic [1:0] yInitSel,
  output logic [4:0] memorySel,
  output logic       black,
  output logic addressScreenCounterReset, screenCountLoad,
  output logic addressSpriteCounterReset, spriteCountLoad,
  output logic plot,
  output logic busy,
  output logic done
);

  state_t state, state_next;

  logic                kind;
  logic [3:0]          prime_cnt;
  logic [COL_BITS-1:0] w;
  logic [ROW_BITS-1:0] h;
  logic [PIX_BITS-1:0] total, pix;
  logic                end_of_row, end_of_frame, addr_more;
  logic                raster_clear, raster_advance, addr_reset, addr_inc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kind      <= 1'b0;
      memorySel <= '0;
      xInitSel  <= '0;
      yInitSel  <= '0;
      black     <= 1'b0;
    end else if (state == S_IDLE && req.req_valid) begin
      kind      <= req.req_kind;
      memorySel <= req.req_mem;
      xInitSel  <= req.req_xsel;
      yInitSel  <= req.req_ysel;
      black     <= req.req_black;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               prime_cnt <= '0;
    else if (state == S_PRIME) prime_cnt <= prime_cnt + 4'd1;
    else                       prime_cnt <= '0;
  end

  assign w     = kind ? COL_BITS'(SPRITE_W) : COL_BITS'(SCREEN_W);
  assign h     = kind ? ROW_BITS'(SPRITE_H) : ROW_BITS'(SCREEN_H);
  assign total = PIX_BITS'(w) * PIX_BITS'(h);

  // PRIME already issued PIPE_LAT addresses beyond address 0, so in DRAW
  // the counter runs ahead of the plotted pixel by PIPE_LAT and stops at W*H-1.
  assign addr_more = ({1'b0, pix} + (PIX_BITS + 1)'(PIPE_LAT + 1)) < {1'b0, total};

  raster_counter u_raster (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (raster_clear),
    .advance      (raster_advance),
    .w            (w),
    .h            (h),
    .pix          (pix),
    .end_of_row   (end_of_row),
    .end_of_frame (end_of_frame)
  );

  always_comb begin
    state_next     = state;
    xInitLoad      = 1'b0;
    yInitLoad      = 1'b0;
    xLoad          = 1'b0;
    yLoad          = 1'b0;
    xCountUp       = 1'b0;
    yCountUp       = 1'b0;
    xReset         = 1'b0;
    yReset         = 1'b0;
    plot           = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    addr_reset     = 1'b0;
    addr_inc       = 1'b0;
    raster_clear   = 1'b0;
    raster_advance = 1'b0;
    unique case (state)
      S_IDLE: if (req.req_valid) state_next = S_INIT;
      S_INIT: begin
        busy         = 1'b1;
        xInitLoad    = 1'b1;
        yInitLoad    = 1'b1;
        xReset       = 1'b1;
        yReset       = 1'b1;
        addr_reset   = 1'b1;
        raster_clear = 1'b1;
        state_next   = S_PRIME;
      end
      S_PRIME: begin
        busy     = 1'b1;
        addr_inc = 1'b1;
        if (prime_cnt == '0) begin
          xLoad = 1'b1;
          yLoad = 1'b1;
        end
        if (prime_cnt == 4'(PIPE_LAT - 1)) state_next = S_DRAW;
      end
      S_DRAW: begin
        busy           = 1'b1;
        plot           = 1'b1;
        raster_advance = 1'b1;
        addr_inc       = addr_more;
        if (end_of_row) begin
          xLoad    = 1'b1;
          yCountUp = 1'b1;
        end else begin
          xCountUp = 1'b1;
        end
        if (end_of_frame) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign req.req_ready = (state == S_IDLE);
  assign xySel         = kind ? XY_SPRITE : XY_SCREEN;

  // Init coordinate registers are always reloaded in INIT, so they never need clearing.
  assign xInitReset = 1'b0;
  assign yInitReset = 1'b0;

  assign addressScreenCounterReset = addr_reset & ~kind;
  assign screenCountLoad           = addr_inc   & ~kind;
  assign addressSpriteCounterReset = addr_reset &  kind;
  assign spriteCountLoad           = addr_inc   &  kind;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: a negedge monitor summarises each
// completed draw into a queue that scenario tasks compare against model records.
module tb_draw_sequencer;
  localparam int SW = 160, SH = 120, PW = 40, PH = 40, LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  draw_sequencer_if req_if();

  logic xInitLoad, yInitLoad, xLoad, yLoad, xCountUp, yCountUp;
  logic xInitReset, yInitReset, xReset, yReset;
  logic [1:0] xySel, yInitSel;
  logic [3:0] xInitSel;
  logic [4:0] memorySel;
  logic black, addressScreenCounterReset, screenCountLoad;
  logic addressSpriteCounterReset, spriteCountLoad, plot, busy, done;

  draw_sequencer #(.SCREEN_W(SW), .SCREEN_H(SH), .SPRITE_W(PW), .SPRITE_H(PH), .PIPE_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req_if),
    .xInitLoad(xInitLoad), .yInitLoad(yInitLoad), .xLoad(xLoad), .yLoad(yLoad),
    .xCountUp(xCountUp), .yCountUp(yCountUp), .xInitReset(xInitReset), .yInitReset(yInitReset),
    .xReset(xReset), .yReset(yReset), .xySel(xySel), .xInitSel(xInitSel), .yInitSel(yInitSel),
    .memorySel(memorySel), .black(black),
    .addressScreenCounterReset(addressScreenCounterReset), .screenCountLoad(screenCountLoad),
    .addressSpriteCounterReset(addressSpriteCounterReset), .spriteCountLoad(spriteCountLoad),
    .plot(plot), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [15:0] plots;
    logic [15:0] scr_inc;
    logic [15:0] spr_inc;
    logic [7:0]  rowends;
    logic        last_rowend;
    logic [1:0]  xysel;
    logic [4:0]  mem;
    logic [3:0]  xsel;
    logic [1:0]  ysel;
    logic        blk;
  } rec_t;

  typedef struct {
    rec_t r;
    int   accept_cyc, first_cyc, last_cyc, done_cyc;
    int   misplaced, fchg, black_zero;
  } obs_t;

  rec_t exp_q[$];
  obs_t obs_q[$];
  int   total = 0, passed = 0;
  int   cyc = 0;
  int   last_accept = 0, cur_plots = 0, done_seen = 0, ready_bad = 0, cur_w = SW;
  bit   in_draw = 0;
  obs_t cur;
  logic [13:0] snap;
  logic [13:0] fields;
  logic [16:0] ctl;

  assign fields = {xySel, memorySel, xInitSel, yInitSel, black};
  assign ctl = {xInitLoad, yInitLoad, xLoad, yLoad, xCountUp, yCountUp, xInitReset, yInitReset,
                xReset, yReset, addressScreenCounterReset, screenCountLoad,
                addressSpriteCounterReset, spriteCountLoad, plot, busy, done};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!resetn) begin
      in_draw = 0;
    end else begin
      if (req_if.req_valid && req_if.req_ready) last_accept = cyc;
      if (req_if.req_ready && (busy || done)) ready_bad++;
      if (done) done_seen++;
      if (xInitLoad) begin
        in_draw = 1;
        cur.r = '0;
        cur.accept_cyc = last_accept;
        cur.first_cyc = 0; cur.last_cyc = 0; cur.done_cyc = 0;
        cur.misplaced = 0; cur.fchg = 0; cur.black_zero = 0;
        snap = fields;
        cur_w = (xySel == 2'b01) ? PW : SW;
        cur_plots = 0;
      end
      if (in_draw) begin
        if (fields !== snap) cur.fchg++;
        if (screenCountLoad) cur.r.scr_inc = cur.r.scr_inc + 16'd1;
        if (spriteCountLoad) cur.r.spr_inc = cur.r.spr_inc + 16'd1;
        if (plot) begin
          if (cur_plots == 0) cur.first_cyc = cyc;
          cur.last_cyc = cyc;
          if (!black) cur.black_zero++;
          if ((xLoad && yCountUp) !== ((cur_plots % cur_w) == cur_w - 1)) cur.misplaced++;
          if (xLoad && yCountUp) cur.r.rowends = cur.r.rowends + 8'd1;
          cur.r.last_rowend = xLoad && yCountUp;
          cur_plots++;
        end
        if (done) begin
          cur.r.plots = 16'(cur_plots);
          cur.done_cyc = cyc;
          {cur.r.xysel, cur.r.mem, cur.r.xsel, cur.r.ysel, cur.r.blk} = snap;
          obs_q.push_back(cur);
          in_draw = 0;
        end
      end
    end
  end

  function automatic rec_t model(input bit kind, input logic [4:0] mem, input logic [3:0] xs,
                                 input logic [1:0] ys, input bit blk);
    rec_t e;
    int w, h;
    w = kind ? PW : SW;
    h = kind ? PH : SH;
    e.plots = 16'(w * h);
    e.scr_inc = kind ? 16'd0 : 16'(w * h - 1);
    e.spr_inc = kind ? 16'(w * h - 1) : 16'd0;
    e.rowends = 8'(h);
    e.last_rowend = 1'b1;
    e.xysel = kind ? 2'b01 : 2'b00;
    e.mem = mem; e.xsel = xs; e.ysel = ys; e.blk = blk;
    return e;
  endfunction

  task automatic drive_fields(input bit kind, input logic [4:0] mem, input logic [3:0] xs,
                              input logic [1:0] ys, input bit blk);
    req_if.req_kind = kind; req_if.req_mem = mem; req_if.req_xsel = xs;
    req_if.req_ysel = ys; req_if.req_black = blk;
  endtask

  task automatic issue(input bit kind, input logic [4:0] mem, input logic [3:0] xs,
                       input logic [1:0] ys, input bit blk);
    int n = 0;
    @(negedge clk);
    drive_fields(kind, mem, xs, ys, blk);
    req_if.req_valid = 1'b1;
    while (!req_if.req_ready && n < 100) begin @(negedge clk); n++; end
    exp_q.push_back(model(kind, mem, xs, ys, blk));
    @(posedge clk); #1 req_if.req_valid = 1'b0;
  endtask

  task automatic wait_obs(input int need, input int budget, output bit ok);
    int n = 0;
    while (obs_q.size() < need && n < budget) begin @(negedge clk); n++; end
    ok = (obs_q.size() >= need);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_if.req_valid = 1'b0;
    drive_fields(0, 5'd0, 4'd0, 2'd0, 0);
    repeat (3) @(negedge clk);
    total++; if (req_if.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_if.req_ready); else passed++;
    total++; if (ctl !== '0) $display("FAIL reset_controls got=%h exp=0", ctl); else passed++;
    total++; if (fields !== '0) $display("FAIL reset_fields got=%h exp=0", fields); else passed++;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (ctl !== '0) $display("FAIL idle_controls got=%h exp=0", ctl); else passed++;
  endtask

  task automatic test_screen();
    bit ok; obs_t o; rec_t e;
    issue(0, 5'd0, 4'd0, 2'd0, 0);
    wait_obs(1, 25000, ok);
    total++; if (!ok) $display("FAIL screen_done got=timeout exp=done"); else passed++;
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.r !== e) $display("FAIL screen_record got=%h exp=%h", o.r, e); else passed++;
      total++; if (o.first_cyc - o.accept_cyc !== 2 + LAT) $display("FAIL screen_latency got=%0d exp=%0d", o.first_cyc - o.accept_cyc, 2 + LAT); else passed++;
      total++; if (o.last_cyc - o.first_cyc + 1 !== 19200) $display("FAIL screen_contiguous got=%0d exp=19200", o.last_cyc - o.first_cyc + 1); else passed++;
      total++; if (o.done_cyc - o.last_cyc !== 1) $display("FAIL screen_done_gap got=%0d exp=1", o.done_cyc - o.last_cyc); else passed++;
      total++; if (o.misplaced !== 0) $display("FAIL screen_rowend_place got=%0d exp=0", o.misplaced); else passed++;
    end else begin exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_sprite();
    bit ok; obs_t o; rec_t e;
    issue(1, 5'd6, 4'd3, 2'd1, 0);
    wait_obs(1, 3000, ok);
    total++; if (!ok) $display("FAIL sprite_done got=timeout exp=done"); else passed++;
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.r !== e) $display("FAIL sprite_record got=%h exp=%h", o.r, e); else passed++;
      total++; if (o.misplaced !== 0) $display("FAIL sprite_rowend_place got=%0d exp=0", o.misplaced); else passed++;
      total++; if (o.fchg !== 0) $display("FAIL sprite_field_hold got=%0d exp=0", o.fchg); else passed++;
      total++; if (o.last_cyc - o.first_cyc + 1 !== 1600) $display("FAIL sprite_contiguous got=%0d exp=1600", o.last_cyc - o.first_cyc + 1); else passed++;
    end else begin exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ok; obs_t o1, o2; rec_t e1, e2;
    int n = 0;
    @(negedge clk);
    drive_fields(1, 5'd17, 4'd3, 2'd1, 0);
    req_if.req_valid = 1'b1;
    while (!req_if.req_ready && n < 100) begin @(negedge clk); n++; end
    exp_q.push_back(model(1, 5'd17, 4'd3, 2'd1, 0));
    @(posedge clk); #1;
    drive_fields(1, 5'd9, 4'd7, 2'd2, 1);
    exp_q.push_back(model(1, 5'd9, 4'd7, 2'd2, 1));
    n = 0;
    do begin @(negedge clk); n++; end while (!req_if.req_ready && n < 5000);
    @(posedge clk); #1 req_if.req_valid = 1'b0;
    wait_obs(2, 3000, ok);
    total++; if (!ok) $display("FAIL b2b_done got=%0d exp=2 draws", obs_q.size()); else passed++;
    if (ok) begin
      o1 = obs_q.pop_front(); e1 = exp_q.pop_front();
      o2 = obs_q.pop_front(); e2 = exp_q.pop_front();
      total++; if (o1.r !== e1) $display("FAIL b2b_first_record got=%h exp=%h", o1.r, e1); else passed++;
      total++; if (o2.r !== e2) $display("FAIL b2b_second_record got=%h exp=%h", o2.r, e2); else passed++;
      total++; if (o2.accept_cyc - o1.done_cyc !== 1) $display("FAIL b2b_accept_gap got=%0d exp=1", o2.accept_cyc - o1.done_cyc); else passed++;
    end else begin exp_q.delete(); obs_q.delete(); end
    total++; if (ready_bad !== 0) $display("FAIL b2b_ready_while_busy got=%0d exp=0", ready_bad); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok; obs_t o; rec_t e;
    int n = 0;
    int done_before;
    issue(0, 5'd3, 4'd2, 2'd1, 0);
    while (cur_plots < 500 && n < 2000) begin @(negedge clk); n++; end
    total++; if (cur_plots < 500) $display("FAIL abort_reach_500 got=%0d exp=500", cur_plots); else passed++;
    done_before = done_seen;
    resetn = 1'b0;
    #1;
    total++; if (plot !== 1'b0) $display("FAIL abort_plot got=%b exp=0", plot); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (done_seen !== done_before || obs_q.size() !== 0) $display("FAIL abort_no_done got=%0d exp=%0d", done_seen, done_before); else passed++;
    exp_q.delete();
    obs_q.delete();
    issue(1, 5'd12, 4'd5, 2'd3, 0);
    wait_obs(1, 3000, ok);
    total++; if (!ok) $display("FAIL post_abort_done got=timeout exp=done"); else passed++;
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.r !== e) $display("FAIL post_abort_record got=%h exp=%h", o.r, e); else passed++;
    end else begin exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_black();
    bit ok; obs_t o; rec_t e;
    issue(0, 5'd21, 4'd1, 2'd2, 1);
    wait_obs(1, 25000, ok);
    total++; if (!ok) $display("FAIL black_done got=timeout exp=done"); else passed++;
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.r !== e) $display("FAIL black_record got=%h exp=%h", o.r, e); else passed++;
      total++; if (o.black_zero !== 0) $display("FAIL black_every_plot got=%0d exp=0", o.black_zero); else passed++;
      total++; if (o.fchg !== 0) $display("FAIL black_field_hold got=%0d exp=0", o.fchg); else passed++;
    end else begin exp_q.delete(); obs_q.delete(); end
  endtask

  initial begin
    req_if.req_valid = 1'b0;
    drive_fields(0, 5'd0, 4'd0, 2'd0, 0);
    test_reset();
    test_screen();
    test_sprite();
    test_back_to_back();
    test_reset_mid();
    test_black();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
